// File: rtl/seven_seg_scan_driver.sv
// =============================================================================
// Module  : seven_seg_scan_driver
// Purpose : Time-multiplexed common-anode 7-segment driver with anti-ghost
//           blanking and frame-boundary shadow buffering. Optional feature
//           macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    data_valid,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] C_BLANK    = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [NUM_DIGITS-1:0]   active_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pend_valid_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_start_q;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [3:0]              w_code;
    logic                    w_dp;
    logic                    w_lzb;
    logic [NUM_DIGITS-1:0]   w_an;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0000011;
            4'd12:   s = 7'b1000110;
            4'd13:   s = 7'b0100001;
            4'd14:   s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (HEX_MODE == 0 && code > 4'd9) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    assign w_slot_end = (div_q == C_DIV_LAST);
    assign w_boundary = w_slot_end && (idx_q == C_IDX_LAST);

    always_comb begin
        w_code = 4'd0;
        w_dp   = 1'b0;
        w_lzb  = 1'b0;
        w_an   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_code = active_q[4*i +: 4];
                w_dp   = active_dp_q[i];
`ifdef LEADING_ZERO_BLANK_EN
                // Blank when this digit and every higher digit are zero.
                w_lzb  = (i != 0) && ((active_q >> (4*i)) == '0);
`endif
                w_an[i] = (div_q < C_BLANK);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            idx_q         <= '0;
            active_q      <= '0;
            active_dp_q   <= '0;
            pend_q        <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            if (w_slot_end) begin
                div_q <= '0;
                idx_q <= (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (data_valid) begin
                pend_q       <= data_in;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end

            // A write landing on the boundary itself bypasses the shadow buffer.
            if (w_boundary) begin
                pend_valid_q <= 1'b0;
                if (data_valid) begin
                    active_q    <= data_in;
                    active_dp_q <= dp_in;
                end else if (pend_valid_q) begin
                    active_q    <= pend_q;
                    active_dp_q <= pend_dp_q;
                end
            end

            seg_q         <= w_lzb ? 7'h7F : decode(w_code);
            dp_q          <= ~w_dp;
            an_q          <= w_an;
            frame_start_q <= w_boundary;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// =============================================================================
// Module  : tb_seven_seg_scan_driver
// Purpose : Directed and random checks of seven_seg_scan_driver against a
//           cycle-count based reference model.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int HEX   = 0;
    localparam int FR    = N * DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] DEC  [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000};
    localparam logic [6:0] HEXT [0:5] = '{7'b0001000, 7'b0000011, 7'b1000110,
        7'b0100001, 7'b0000110, 7'b0001110};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4*N-1:0]   data_in = '0;
    logic [N-1:0]     dp_in = '0;
    logic             data_valid = 1'b0;
    logic [6:0]       seg;
    logic             dp;
    logic [N-1:0]     an;
    logic             frame_start;

    int checks = 0;
    int failures = 0;

    // Reference model: cycle number since reset release plus displayed/pending data.
    int             n;
    logic [4*N-1:0] m_act, m_pend;
    logic [N-1:0]   m_adp, m_pdp;
    bit             m_pv;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK),
        .HEX_MODE    (HEX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .data_valid (data_valid),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [4*N-1:0] a, input int i);
        int code;
        code = int'((a >> (4*i)) & 4'hF);
        if (LZB && i > 0 && (a >> (4*i)) == 0) return 7'h7F;
        if (code < 10) return DEC[code];
        return (HEX != 0) ? HEXT[code-10] : 7'h7F;
    endfunction

    function automatic void model_reset();
        n = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
    endfunction

    task automatic step(input logic v, input logic [4*N-1:0] d, input logic [N-1:0] p);
        int div, idx;
        bit bnd;
        logic [N-1:0] one;
        logic [6:0] e_seg;
        logic e_dp;
        logic [N-1:0] e_an;
        data_valid = v; data_in = d; dp_in = p;
        div = n % DIV;
        idx = (n / DIV) % N;
        bnd = (n % FR) == FR - 1;
        one = 1;
        e_seg = seg_of(m_act, idx);
        e_dp  = ~m_adp[idx];
        e_an  = (div >= BLANK) ? ~(one << idx) : '1;
        if (bnd) begin
            if (v) begin m_act = d; m_adp = p; end
            else if (m_pv) begin m_act = m_pend; m_adp = m_pdp; end
            m_pv = 1'b0;
        end else if (v) begin
            m_pend = d; m_pdp = p; m_pv = 1'b1;
        end
        @(posedge clk); #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("an", 32'(an), 32'(e_an));
        chk("frame_start", 32'(frame_start), 32'(bnd));
        n++;
        data_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, '0, '0);
    endtask

    // Idle until the next edge is at frame phase ph, then write on that edge.
    task automatic write_at(input int ph, input logic [4*N-1:0] d, input logic [N-1:0] p);
        while ((n % FR) != ph) step(1'b0, '0, '0);
        step(1'b1, d, p);
    endtask

    task automatic check_reset_outputs();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fs", 32'(frame_start), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        idle(20);
        write_at(6, 16'h1234, 4'b0100);
        idle(2 * FR);
        write_at(3, 16'h1111, 4'b0000);
        write_at(8, 16'h2222, 4'b0001);
        idle(2 * FR);
        write_at(FR - 1, 16'h0009, 4'b0000);
        idle(FR + 2);
        write_at(5, 16'h0050, 4'b0000);
        idle(2 * FR);
        write_at(5, 16'hABCF, 4'b1000);
        idle(2 * FR);
        write_at(5, 16'h0000, 4'b1111);
        idle(2 * FR);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 6) == 0, 16'($urandom), 4'($urandom));
        end

        // Asynchronous reset mid-frame with a write still pending.
        write_at(7, 16'h8888, 4'b1111);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2 * FR);
        for (int i = 0; i < 200; i++) begin
            step(($urandom % 4) == 0, 16'($urandom), 4'($urandom));
        end
        idle(FR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
